// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus definitions: bus geometry, source indices and selector modes.
package cpu_bus_pkg;

  localparam int BUS_W     = 32;
  localparam int N_BUS_SRC = 24;

  // Bus source indices; a lower index has higher priority on the bus.
  localparam int SRC_R0     = 0;
  localparam int SRC_R1     = 1;
  localparam int SRC_R2     = 2;
  localparam int SRC_R3     = 3;
  localparam int SRC_R4     = 4;
  localparam int SRC_R5     = 5;
  localparam int SRC_R6     = 6;
  localparam int SRC_R7     = 7;
  localparam int SRC_R8     = 8;
  localparam int SRC_R9     = 9;
  localparam int SRC_R10    = 10;
  localparam int SRC_R11    = 11;
  localparam int SRC_R12    = 12;
  localparam int SRC_R13    = 13;
  localparam int SRC_R14    = 14;
  localparam int SRC_R15    = 15;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHI    = 18;
  localparam int SRC_ZLO    = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_C      = 22;
  localparam int SRC_INPORT = 23;

  // Selector arbitration modes.
  localparam int MODE_PRIORITY = 0;  // lowest asserted index wins
  localparam int MODE_ONEHOT   = 1;  // more than one enable selects nothing

endpackage

// File: rtl/bus_prio_encoder.sv
// Combinational decode of the per-source drive enables: lowest asserted
// index, whether any enable is set, and whether two or more are set.
module bus_prio_encoder
  import cpu_bus_pkg::*;
#(
  parameter int N_SRC = N_BUS_SRC,
  parameter int IDX_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] sel_i,
  output logic [IDX_W-1:0] win_idx_o,
  output logic             any_o,
  output logic             conflict_o
);

  // Scan from the top so the last hit, i.e. the lowest asserted index, sticks.
  always_comb begin
    win_idx_o = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (sel_i[k]) win_idx_o = IDX_W'(k);
    end
  end

  // Clearing the lowest set bit leaves something only when two or more were set.
  assign any_o      = |sel_i;
  assign conflict_o = |(sel_i & (sel_i - N_SRC'(1)));

endmodule

// File: rtl/bus_select_reg.sv
// Registered CPU bus source selector with multi-driver conflict detection,
// sticky error flag, saturating conflict counter and optional bus keeper.
module bus_select_reg
  import cpu_bus_pkg::*;
#(
  parameter int N_SRC  = N_BUS_SRC,
  parameter int W      = BUS_W,
  parameter int MODE   = MODE_PRIORITY,
  parameter int KEEPER = 1,
  parameter int CNT_W  = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [N_SRC-1:0]         sel_i,
  input  logic [N_SRC*W-1:0]       data_i,
  input  logic                     err_clr_i,
  output logic [W-1:0]             bus_o,
  output logic                     bus_valid_o,
  output logic [$clog2(N_SRC)-1:0] src_idx_o,
  output logic                     conflict_o,
  output logic                     err_sticky_o,
  output logic [CNT_W-1:0]         conflict_cnt_o
);

  localparam int IDX_W = $clog2(N_SRC);

  logic [IDX_W-1:0] win_idx;
  logic             any_sel;
  logic             conflict;
  logic             win_valid;
  logic [W-1:0]     win_data;

  bus_prio_encoder #(
    .N_SRC (N_SRC),
    .IDX_W (IDX_W)
  ) u_enc (
    .sel_i      (sel_i),
    .win_idx_o  (win_idx),
    .any_o      (any_sel),
    .conflict_o (conflict)
  );

  // In one-hot mode a conflict leaves the bus undriven rather than guessing.
  assign win_valid = (MODE == MODE_ONEHOT) ? (any_sel & ~conflict) : any_sel;

  // Only the winning slice is read, so junk on unselected sources never reaches the bus.
  assign win_data = data_i[win_idx*W +: W];

  // Bus register: load the winner, otherwise keep or discharge the bus.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus_o       <= '0;
      bus_valid_o <= 1'b0;
      src_idx_o   <= '0;
      conflict_o  <= 1'b0;
    end else begin
      conflict_o  <= conflict;
      bus_valid_o <= win_valid;
      if (win_valid) begin
        bus_o     <= win_data;
        src_idx_o <= win_idx;
      end else if (KEEPER == 0) begin
        bus_o     <= '0;
      end
    end
  end

  // Error status: a conflict in the clearing cycle outranks the clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_sticky_o   <= 1'b0;
      conflict_cnt_o <= '0;
    end else begin
      err_sticky_o <= (err_sticky_o & ~err_clr_i) | conflict;
      if (err_clr_i) begin
        conflict_cnt_o <= CNT_W'(conflict);
      end else if (conflict && (conflict_cnt_o != {CNT_W{1'b1}})) begin
        conflict_cnt_o <= conflict_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bus_select_reg.sv
// Self-checking bench for bus_select_reg: four parameter variants share one
// stimulus stream; a behavioural model feeds a scoreboard queue, and a table
// of hand-derived values plus directed sequences pin down the corner cases.
module tb_bus_select_reg;
  import cpu_bus_pkg::*;

  localparam int N = 24;
  localparam int W = 32;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [N-1:0]     sel_i;
  logic [N*W-1:0]   data_i;
  logic             err_clr_i;

  logic [W-1:0] bus_a    [4];
  logic         valid_a  [4];
  logic [4:0]   idx_a    [4];
  logic         conf_a   [4];
  logic         sticky_a [4];
  logic [7:0]   cnt_p, cnt_h, cnt_z;
  logic [1:0]   cnt_s;

  always #5 clock = ~clock;

  // u_p: priority/keeper, u_h: one-hot/keeper, u_z: one-hot/no keeper, u_s: 2-bit counter
  bus_select_reg #(.N_SRC(N), .W(W), .MODE(0), .KEEPER(1), .CNT_W(8)) u_p (
    .clock(clock), .reset_n(reset_n), .sel_i(sel_i), .data_i(data_i), .err_clr_i(err_clr_i),
    .bus_o(bus_a[0]), .bus_valid_o(valid_a[0]), .src_idx_o(idx_a[0]), .conflict_o(conf_a[0]),
    .err_sticky_o(sticky_a[0]), .conflict_cnt_o(cnt_p));
  bus_select_reg #(.N_SRC(N), .W(W), .MODE(1), .KEEPER(1), .CNT_W(8)) u_h (
    .clock(clock), .reset_n(reset_n), .sel_i(sel_i), .data_i(data_i), .err_clr_i(err_clr_i),
    .bus_o(bus_a[1]), .bus_valid_o(valid_a[1]), .src_idx_o(idx_a[1]), .conflict_o(conf_a[1]),
    .err_sticky_o(sticky_a[1]), .conflict_cnt_o(cnt_h));
  bus_select_reg #(.N_SRC(N), .W(W), .MODE(1), .KEEPER(0), .CNT_W(8)) u_z (
    .clock(clock), .reset_n(reset_n), .sel_i(sel_i), .data_i(data_i), .err_clr_i(err_clr_i),
    .bus_o(bus_a[2]), .bus_valid_o(valid_a[2]), .src_idx_o(idx_a[2]), .conflict_o(conf_a[2]),
    .err_sticky_o(sticky_a[2]), .conflict_cnt_o(cnt_z));
  bus_select_reg #(.N_SRC(N), .W(W), .MODE(0), .KEEPER(1), .CNT_W(2)) u_s (
    .clock(clock), .reset_n(reset_n), .sel_i(sel_i), .data_i(data_i), .err_clr_i(err_clr_i),
    .bus_o(bus_a[3]), .bus_valid_o(valid_a[3]), .src_idx_o(idx_a[3]), .conflict_o(conf_a[3]),
    .err_sticky_o(sticky_a[3]), .conflict_cnt_o(cnt_s));

  typedef struct packed {
    logic [31:0] bus;
    logic        valid;
    logic [4:0]  idx;
    logic        conf;
    logic        sticky;
    logic [7:0]  cnt;
  } exp_t;
  typedef exp_t [3:0] exp4_t;

  typedef struct {
    logic [N-1:0] sel;
    int           ai;
    logic [31:0]  av;
    int           bi;
    logic [31:0]  bv;
    logic         clr;
    exp_t         e;
  } vec_t;

  int    p_mode [4] = '{0, 1, 1, 0};
  int    p_keep [4] = '{1, 1, 0, 1};
  int    p_max  [4] = '{255, 255, 255, 3};
  exp_t  mst    [4];
  logic [31:0] md [N];
  exp4_t sb [$];
  vec_t  tab [12];
  int    total = 0;
  int    bad   = 0;

  function automatic exp_t get_act(int k);
    exp_t a;
    a.bus    = bus_a[k];
    a.valid  = valid_a[k];
    a.idx    = idx_a[k];
    a.conf   = conf_a[k];
    a.sticky = sticky_a[k];
    case (k)
      0:       a.cnt = cnt_p;
      1:       a.cnt = cnt_h;
      2:       a.cnt = cnt_z;
      default: a.cnt = {6'd0, cnt_s};
    endcase
    return a;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic chk_inst(int k, exp_t e, string tag);
    exp_t a;
    a = get_act(k);
    chk($sformatf("%s/u%0d bus", tag, k),    a.bus,    e.bus);
    chk($sformatf("%s/u%0d valid", tag, k),  32'(a.valid),  32'(e.valid));
    chk($sformatf("%s/u%0d idx", tag, k),    32'(a.idx),    32'(e.idx));
    chk($sformatf("%s/u%0d conf", tag, k),   32'(a.conf),   32'(e.conf));
    chk($sformatf("%s/u%0d sticky", tag, k), 32'(a.sticky), 32'(e.sticky));
    chk($sformatf("%s/u%0d cnt", tag, k),    32'(a.cnt),    32'(e.cnt));
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) mst[k] = '0;
    sb.delete();
  endtask

  // Behavioural next state for each variant, pushed as the expectation for the next edge.
  task automatic model_step();
    int    nsel;
    int    win;
    bit    cf;
    bit    wins;
    exp4_t e;
    nsel = $countones(sel_i);
    win  = 0;
    for (int j = N - 1; j >= 0; j--) if (sel_i[j]) win = j;
    cf = (nsel >= 2);
    for (int k = 0; k < 4; k++) begin
      wins = (p_mode[k] == 0) ? (nsel >= 1) : (nsel == 1);
      if (wins) begin
        mst[k].bus = md[win];
        mst[k].idx = 5'(win);
      end else if (p_keep[k] == 0) begin
        mst[k].bus = '0;
      end
      mst[k].valid  = wins;
      mst[k].conf   = cf;
      mst[k].sticky = (mst[k].sticky & ~err_clr_i) | cf;
      if (err_clr_i) mst[k].cnt = cf ? 8'd1 : 8'd0;
      else if (cf && (int'(mst[k].cnt) < p_max[k])) mst[k].cnt = mst[k].cnt + 8'd1;
      e[k] = mst[k];
    end
    sb.push_back(e);
  endtask

  task automatic drive(logic [N-1:0] sel, int ai, logic [31:0] av, int bi, logic [31:0] bv, logic clr);
    sel_i     = sel;
    err_clr_i = clr;
    data_i    = 'x;
    for (int j = 0; j < N; j++) md[j] = 'x;
    if (ai >= 0) begin data_i[ai*W +: W] = av; md[ai] = av; end
    if (bi >= 0) begin data_i[bi*W +: W] = bv; md[bi] = bv; end
    model_step();
  endtask

  task automatic cycle(logic [N-1:0] sel, int ai, logic [31:0] av, int bi, logic [31:0] bv,
                       logic clr, string tag);
    exp4_t e;
    drive(sel, ai, av, bi, bv, clr);
    @(posedge clock);
    @(negedge clock);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      for (int k = 0; k < 4; k++) chk_inst(k, e[k], tag);
    end
  endtask

  function automatic vec_t mkv(logic [N-1:0] sel, int ai, logic [31:0] av, int bi, logic [31:0] bv,
                               logic clr, logic [31:0] bus, logic valid, logic [4:0] idx,
                               logic conf, logic sticky, logic [7:0] cnt);
    vec_t v;
    v.sel = sel; v.ai = ai; v.av = av; v.bi = bi; v.bv = bv; v.clr = clr;
    v.e.bus = bus; v.e.valid = valid; v.e.idx = idx;
    v.e.conf = conf; v.e.sticky = sticky; v.e.cnt = cnt;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t z;
    exp_t a;
    int   sat [5] = '{1, 2, 3, 3, 3};
    z = '0;

    // Expected values for u_p (priority, keeper, 8-bit counter), derived by hand.
    tab[0]  = mkv(24'h000000, -1, 0, -1, 0, 0, 32'h0, 0, 0, 0, 0, 0);
    tab[1]  = mkv(24'h200000, 21, 32'hDEADBEEF, -1, 0, 0, 32'hDEADBEEF, 1, 21, 0, 0, 0);
    tab[2]  = mkv(24'h000000, -1, 0, -1, 0, 0, 32'hDEADBEEF, 0, 21, 0, 0, 0);
    tab[3]  = mkv(24'h100008, 3, 32'h11, 20, 32'h22, 0, 32'h11, 1, 3, 1, 1, 1);
    tab[4]  = mkv(24'h800000, 23, 32'h12345678, -1, 0, 0, 32'h12345678, 1, 23, 0, 1, 1);
    tab[5]  = mkv(24'h000021, 0, 32'hCAFE0000, 5, 32'hBAD, 0, 32'hCAFE0000, 1, 0, 1, 1, 2);
    tab[6]  = mkv(24'h000000, -1, 0, -1, 0, 1, 32'hCAFE0000, 0, 0, 0, 0, 0);
    tab[7]  = mkv(24'h010000, 16, 32'h1, -1, 0, 0, 32'h1, 1, 16, 0, 0, 0);
    tab[8]  = mkv(24'hC00000, 22, 32'hC0C0C0C0, 23, 32'h5, 0, 32'hC0C0C0C0, 1, 22, 1, 1, 1);
    tab[9]  = mkv(24'h000006, 1, 32'h77, 2, 32'h88, 1, 32'h77, 1, 1, 1, 1, 1);
    tab[10] = mkv(24'h000000, -1, 0, -1, 0, 0, 32'h77, 0, 1, 0, 1, 1);
    tab[11] = mkv(24'h000000, -1, 0, -1, 0, 1, 32'h77, 0, 1, 0, 0, 0);

    // Power-up reset
    reset_n = 1'b1; sel_i = '0; data_i = '0; err_clr_i = 1'b0;
    #2 reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    for (int k = 0; k < 4; k++) chk_inst(k, z, "por");
    reset_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      cycle(tab[i].sel, tab[i].ai, tab[i].av, tab[i].bi, tab[i].bv, tab[i].clr,
            $sformatf("tab%0d", i));
      chk_inst(0, tab[i].e, $sformatf("tabref%0d", i));
    end

    // One-hot conflict with and without keeper
    cycle(24'h1, 0, 32'hA5, -1, 0, 0, "oh_load");
    chk("oh_load u_h bus", bus_a[1], 32'hA5);
    cycle(24'h3, 0, 32'h5A, 1, 32'h3C, 0, "oh_conf");
    chk("oh_conf u_h bus", bus_a[1], 32'hA5);
    chk("oh_conf u_h valid", 32'(valid_a[1]), 32'd0);
    chk("oh_conf u_h conf", 32'(conf_a[1]), 32'd1);
    chk("oh_conf u_z bus", bus_a[2], 32'h0);
    chk("oh_conf u_p bus", bus_a[0], 32'h5A);
    cycle(24'h1, 0, 32'hA5, -1, 0, 0, "nk_load");
    chk("nk_load u_z bus", bus_a[2], 32'hA5);
    cycle(24'h0, -1, 0, -1, 0, 0, "nk_idle");
    chk("nk_idle u_z bus", bus_a[2], 32'h0);
    chk("nk_idle u_h bus", bus_a[1], 32'hA5);
    chk("nk_idle u_h conf", 32'(conf_a[1]), 32'd0);
    cycle(24'h0, -1, 0, -1, 0, 1, "clr0");

    // 2-bit counter saturation
    for (int i = 0; i < 5; i++) begin
      cycle(24'h90, 4, 32'h44, 7, 32'h77, 0, $sformatf("sat%0d", i));
      chk($sformatf("sat%0d u_s cnt", i), 32'(cnt_s), 32'(sat[i]));
    end
    cycle(24'h0, -1, 0, -1, 0, 1, "sat_clr");
    chk("sat_clr u_s cnt", 32'(cnt_s), 32'd0);
    chk("sat_clr u_s sticky", 32'(sticky_a[3]), 32'd0);

    // Clear colliding with a conflict
    for (int i = 0; i < 7; i++) cycle(24'h900, 8, 32'h8, 11, 32'hB, 0, $sformatf("c7_%0d", i));
    chk("c7 u_p cnt", 32'(cnt_p), 32'd7);
    cycle(24'h900, 8, 32'h8, 11, 32'hB, 1, "clr_coll");
    chk("clr_coll u_p cnt", 32'(cnt_p), 32'd1);
    chk("clr_coll u_p sticky", 32'(sticky_a[0]), 32'd1);

    // Asynchronous reset mid-run with a source still enabled
    drive(24'h200000, 21, 32'hDEADBEEF, -1, 0, 0);
    @(posedge clock);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 4; k++) chk_inst(k, z, "async_rst");
    @(posedge clock);
    #1;
    a = get_act(0);
    chk("rst_hold u_p bus", a.bus, 32'h0);
    chk("rst_hold u_p valid", 32'(a.valid), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    cycle(24'h0, -1, 0, -1, 0, 0, "post_rst");
    chk("post_rst u_p bus", bus_a[0], 32'h0);
    chk("post_rst u_p valid", 32'(valid_a[0]), 32'd0);
    cycle(24'h400000, 22, 32'h0BADF00D, -1, 0, 0, "post_rst_load");
    chk("post_rst_load u_p idx", 32'(idx_a[0]), 32'd22);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
